dpa_datapath: RTL and testbench

- Datapath companion to the DPA control FSM.
- Captures configuration words read from image memory (im_q) under one-cycle load enables from the controller. Runs the real-time clock that the controller polls as curr_time.
- Buffers serial-in pixels, optionally averaging pairs, and drives the serial-out word im_d written back to the frame buffer.
- Consumes the controller's enables; produces every status field the controller reads.

---
 rtl/dpa_pkg.sv | 26 ++
 rtl/dpa_rtc.sv | 52 +++++
 rtl/dpa_datapath.sv | 93 +++++++++
 tb/tb_dpa_datapath.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dpa_pkg.sv
// Shared constants and helpers for the DPA datapath: RTC limits, field positions
// and photo size codes.
package dpa_pkg;

  localparam int CH_W = 8;

  localparam logic [CH_W-1:0] SEC_MAX  = 8'd59;
  localparam logic [CH_W-1:0] MIN_MAX  = 8'd59;
  localparam logic [CH_W-1:0] HOUR_MAX = 8'd23;

  localparam int SS_LSB = 0;
  localparam int MM_LSB = 8;
  localparam int HH_LSB = 16;

  typedef enum logic [1:0] {
    SZ_DIRECT = 2'd0,
    SZ_AVG256 = 2'd1,
    SZ_AVG512 = 2'd2,
    SZ_RSVD   = 2'd3
  } size_e;

  function automatic logic size_is_avg(input logic [1:0] sz);
    return (size_e'(sz) == SZ_AVG256) || (size_e'(sz) == SZ_AVG512);
  endfunction

endpackage

// File: rtl/dpa_rtc.sv
// Real-time clock {hh,mm,ss}: loadable, advanced by a one-second strobe with
// cascaded wrap, and a registered change pulse.
module dpa_rtc
  import dpa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] time_in,
  input  logic        load,
  input  logic        sec_tick,
  output logic [23:0] curr_time,
  output logic        time_upd
);

  logic [CH_W-1:0] ss, mm, hh;
  logic [CH_W-1:0] ss_next, mm_next, hh_next;
  logic            ss_wrap, mm_wrap, hh_wrap;

  // Wrap on >= so a loaded out-of-range field returns to zero on the next tick.
  always_comb begin
    ss = curr_time[SS_LSB +: CH_W];
    mm = curr_time[MM_LSB +: CH_W];
    hh = curr_time[HH_LSB +: CH_W];

    ss_wrap = (ss >= SEC_MAX);
    mm_wrap = (mm >= MIN_MAX);
    hh_wrap = (hh >= HOUR_MAX);

    ss_next = ss_wrap ? '0 : ss + 8'd1;
    mm_next = mm;
    hh_next = hh;
    if (ss_wrap) begin
      mm_next = mm_wrap ? '0 : mm + 8'd1;
      if (mm_wrap) hh_next = hh_wrap ? '0 : hh + 8'd1;
    end
  end

  // A load wins over a coincident tick; that tick is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curr_time <= '0;
      time_upd  <= 1'b0;
    end else begin
      if (load)
        curr_time <= time_in;
      else if (sec_tick)
        curr_time <= {hh_next, mm_next, ss_next};
      time_upd <= load | sec_tick;
    end
  end

endmodule

// File: rtl/dpa_datapath.sv
// DPA datapath: configuration capture from image memory, RTC, and the two-entry
// pixel buffer feeding the serial-out word (direct copy or pairwise average).
module dpa_datapath
  import dpa_pkg::*;
#(
  parameter int DW = 24,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] im_q,
  input  logic          sec_tick,
  input  logic          en_init_time,
  input  logic          init_time_mux_sel,
  input  logic          en_fb_addr,
  input  logic          en_photo_num,
  input  logic          en_curr_photo_addr,
  input  logic          en_curr_photo_size,
  input  logic          en_si,
  input  logic          en_so,
  output logic [23:0]   curr_time,
  output logic          time_upd,
  output logic [AW-1:0] fb_addr,
  output logic [1:0]    photo_num,
  output logic [AW-1:0] curr_photo_addr,
  output logic [1:0]    curr_photo_size,
  output logic [DW-1:0] im_d
);

  localparam int NCH = DW / CH_W;

  logic [DW-1:0] si0, si1, so;
  logic [DW-1:0] avg_word;
  logic          rtc_load;

  function automatic logic [CH_W-1:0] avg_ch(input logic [CH_W-1:0] a,
                                             input logic [CH_W-1:0] b);
    logic [CH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CH_W:1];
  endfunction

  assign rtc_load = en_init_time & ~init_time_mux_sel;

  dpa_rtc u_rtc (
    .clk       (clk),
    .reset     (reset),
    .time_in   (im_q[23:0]),
    .load      (rtc_load),
    .sec_tick  (sec_tick),
    .curr_time (curr_time),
    .time_upd  (time_upd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_addr         <= '0;
      photo_num       <= '0;
      curr_photo_addr <= '0;
      curr_photo_size <= '0;
    end else begin
      if (en_fb_addr)         fb_addr         <= im_q[AW-1:0];
      if (en_photo_num)       photo_num       <= im_q[1:0];
      if (en_curr_photo_addr) curr_photo_addr <= im_q[AW-1:0];
      if (en_curr_photo_size) curr_photo_size <= im_q[1:0];
    end
  end

  always_comb begin
    avg_word = '0;
    for (int c = 0; c < NCH; c++)
      avg_word[c*CH_W +: CH_W] = avg_ch(si0[c*CH_W +: CH_W], si1[c*CH_W +: CH_W]);
  end

  // so samples si0/si1 as they stood before any same-edge shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      si0 <= '0;
      si1 <= '0;
      so  <= '0;
    end else begin
      if (en_si) begin
        si1 <= si0;
        si0 <= im_q;
      end
      if (en_so)
        so <= size_is_avg(curr_photo_size) ? avg_word : si0;
    end
  end

  assign im_d = so;

endmodule

// File: tb/tb_dpa_datapath.sv
// Bench for dpa_datapath: vector table through a scoreboard queue, plus an
// asynchronous mid-run reset sequence.
module tb_dpa_datapath;

  localparam int DW = 24;
  localparam int AW = 20;

  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] MSEL = 9'h100;
  localparam logic [8:0] T_LD = 9'h080;
  localparam logic [8:0] TICK = 9'h040;
  localparam logic [8:0] FB   = 9'h020;
  localparam logic [8:0] PN   = 9'h010;
  localparam logic [8:0] PA   = 9'h008;
  localparam logic [8:0] PS   = 9'h004;
  localparam logic [8:0] SI   = 9'h002;
  localparam logic [8:0] SO   = 9'h001;

  typedef struct {
    logic [8:0]  ctl;
    logic [23:0] q;
    logic [23:0] e_time;
    logic        e_upd;
    logic [23:0] e_imd;
    logic [19:0] e_fb;
    logic [1:0]  e_pn;
    logic [19:0] e_pa;
    logic [1:0]  e_ps;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] im_q;
  logic          sec_tick, en_init_time, init_time_mux_sel;
  logic          en_fb_addr, en_photo_num, en_curr_photo_addr, en_curr_photo_size;
  logic          en_si, en_so;
  logic [23:0]   curr_time;
  logic          time_upd;
  logic [AW-1:0] fb_addr, curr_photo_addr;
  logic [1:0]    photo_num, curr_photo_size;
  logic [DW-1:0] im_d;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];
  vec_t sb[$];

  dpa_datapath #(.DW(DW), .AW(AW)) dut (
    .clk                (clk),
    .reset              (reset),
    .im_q               (im_q),
    .sec_tick           (sec_tick),
    .en_init_time       (en_init_time),
    .init_time_mux_sel  (init_time_mux_sel),
    .en_fb_addr         (en_fb_addr),
    .en_photo_num       (en_photo_num),
    .en_curr_photo_addr (en_curr_photo_addr),
    .en_curr_photo_size (en_curr_photo_size),
    .en_si              (en_si),
    .en_so              (en_so),
    .curr_time          (curr_time),
    .time_upd           (time_upd),
    .fb_addr            (fb_addr),
    .photo_num          (photo_num),
    .curr_photo_addr    (curr_photo_addr),
    .curr_photo_size    (curr_photo_size),
    .im_d               (im_d)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [8:0] ctl, input logic [23:0] q,
                              input logic [23:0] t, input logic u, input logic [23:0] d,
                              input logic [19:0] fb, input logic [1:0] pn,
                              input logic [19:0] pa, input logic [1:0] ps);
    vec_t v;
    v.ctl = ctl; v.q = q; v.e_time = t; v.e_upd = u; v.e_imd = d;
    v.e_fb = fb; v.e_pn = pn; v.e_pa = pa; v.e_ps = ps;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input vec_t e);
    chk({tag, " curr_time"}, curr_time, e.e_time);
    chk({tag, " time_upd"}, {23'd0, time_upd}, {23'd0, e.e_upd});
    chk({tag, " im_d"}, im_d, e.e_imd);
    chk({tag, " fb_addr"}, {4'd0, fb_addr}, {4'd0, e.e_fb});
    chk({tag, " photo_num"}, {22'd0, photo_num}, {22'd0, e.e_pn});
    chk({tag, " photo_addr"}, {4'd0, curr_photo_addr}, {4'd0, e.e_pa});
    chk({tag, " photo_size"}, {22'd0, curr_photo_size}, {22'd0, e.e_ps});
  endtask

  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    {init_time_mux_sel, en_init_time, sec_tick, en_fb_addr, en_photo_num,
     en_curr_photo_addr, en_curr_photo_size, en_si, en_so} = v.ctl;
    im_q = v.q;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp(tag, e);
  endtask

  initial begin
    vec_t zero;
    reset = 1'b1;
    im_q = '0;
    {init_time_mux_sel, en_init_time, sec_tick, en_fb_addr, en_photo_num,
     en_curr_photo_addr, en_curr_photo_size, en_si, en_so} = NONE;
    zero = mk(NONE, 0, 0, 0, 0, 0, 0, 0, 0);

    // RTC: load, tick, full wrap, ignored load, dropped tick, carries
    vecs.push_back(mk(NONE,        24'h000000, 24'h000000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(T_LD,        24'h173B3A, 24'h173B3A, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(TICK,        24'h000000, 24'h173B3B, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(TICK,        24'h000000, 24'h000000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(NONE,        24'h000000, 24'h000000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(MSEL|T_LD|TICK, 24'h010203, 24'h000001, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(MSEL|T_LD,   24'h050505, 24'h000001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(T_LD|TICK,   24'h0A0B0C, 24'h0A0B0C, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(T_LD,        24'h00003B, 24'h00003B, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(TICK,        24'h000000, 24'h000100, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(T_LD,        24'h003B3B, 24'h003B3B, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(TICK,        24'h000000, 24'h010000, 1, 0, 0, 0, 0, 0));
    // Configuration loads
    vecs.push_back(mk(FB,          24'h0FFFFF, 24'h010000, 0, 0, 20'hFFFFF, 0, 0, 0));
    vecs.push_back(mk(PN,          24'h000003, 24'h010000, 0, 0, 20'hFFFFF, 3, 0, 0));
    vecs.push_back(mk(FB|PA,       24'h0ABCDE, 24'h010000, 0, 0, 20'hABCDE, 3, 20'hABCDE, 0));
    // Pixel path: direct, averaged, same-edge shift, sizes 3 and 2
    vecs.push_back(mk(SI,    24'h102030, 24'h010000, 0, 24'h000000, 20'hABCDE, 3, 20'hABCDE, 0));
    vecs.push_back(mk(SO,    24'h000000, 24'h010000, 0, 24'h102030, 20'hABCDE, 3, 20'hABCDE, 0));
    vecs.push_back(mk(PS,    24'h000001, 24'h010000, 0, 24'h102030, 20'hABCDE, 3, 20'hABCDE, 1));
    vecs.push_back(mk(SI,    24'hFF0001, 24'h010000, 0, 24'h102030, 20'hABCDE, 3, 20'hABCDE, 1));
    vecs.push_back(mk(SI,    24'h01FF02, 24'h010000, 0, 24'h102030, 20'hABCDE, 3, 20'hABCDE, 1));
    vecs.push_back(mk(SO,    24'h000000, 24'h010000, 0, 24'h807F01, 20'hABCDE, 3, 20'hABCDE, 1));
    vecs.push_back(mk(SI|SO, 24'h000000, 24'h010000, 0, 24'h807F01, 20'hABCDE, 3, 20'hABCDE, 1));
    vecs.push_back(mk(SO,    24'h000000, 24'h010000, 0, 24'h007F01, 20'hABCDE, 3, 20'hABCDE, 1));
    vecs.push_back(mk(SI,    24'hAABBCC, 24'h010000, 0, 24'h007F01, 20'hABCDE, 3, 20'hABCDE, 1));
    vecs.push_back(mk(PS,    24'h000003, 24'h010000, 0, 24'h007F01, 20'hABCDE, 3, 20'hABCDE, 3));
    vecs.push_back(mk(SO,    24'h000000, 24'h010000, 0, 24'hAABBCC, 20'hABCDE, 3, 20'hABCDE, 3));
    vecs.push_back(mk(PS,    24'h000002, 24'h010000, 0, 24'hAABBCC, 20'hABCDE, 3, 20'hABCDE, 2));
    vecs.push_back(mk(SO,    24'h000000, 24'h010000, 0, 24'h555D66, 20'hABCDE, 3, 20'hABCDE, 2));
    vecs.push_back(mk(PS|SO, 24'h000000, 24'h010000, 0, 24'h555D66, 20'hABCDE, 3, 20'hABCDE, 0));
    vecs.push_back(mk(SO,    24'h000000, 24'h010000, 0, 24'hAABBCC, 20'hABCDE, 3, 20'hABCDE, 0));

    repeat (2) @(posedge clk);
    #1;
    cmp("reset", zero);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("v%0d", i), vecs[i]);

    // Mid-run asynchronous reset with live time and pixel output
    apply("pre_rst0", mk(T_LD, 24'h123456, 24'h123456, 1, 24'hAABBCC, 20'hABCDE, 3, 20'hABCDE, 0));
    apply("pre_rst1", mk(SI,   24'hABCDEF, 24'h123456, 0, 24'hAABBCC, 20'hABCDE, 3, 20'hABCDE, 0));
    apply("pre_rst2", mk(SO,   24'h000000, 24'h123456, 0, 24'hABCDEF, 20'hABCDE, 3, 20'hABCDE, 0));
    @(negedge clk);
    {init_time_mux_sel, en_init_time, sec_tick, en_fb_addr, en_photo_num,
     en_curr_photo_addr, en_curr_photo_size, en_si, en_so} = NONE;
    #1 reset = 1'b1;
    #1;
    cmp("rst_async", zero);
    @(posedge clk);
    #1;
    cmp("rst_held", zero);
    @(negedge clk);
    reset = 1'b0;
    apply("post_rst", zero);
    apply("post_tick", mk(TICK, 24'h000000, 24'h000001, 1, 0, 0, 0, 0, 0));
    apply("post_idle", mk(NONE, 24'h000000, 24'h000001, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
